// File: rtl/mips_core_ctrl_exec.sv
// rtl/mips_core_ctrl_exec.sv - single-cycle MIPS decoder, ALU, next-PC logic and PC register
// Optional feature macro: SLT_EN (decodes slt and drives slt_o; otherwise slt is an unknown op).
module mips_core_ctrl_exec #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_AW    = 10
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [31:0]      ins_i,
  input  logic [31:0]      rs_data_i,
  input  logic [31:0]      rt_data_i,
  input  logic [31:0]      ext_imm_i,
  output logic [31:0]      pc_o,
  output logic [IM_AW-1:0] im_addr_o,
  output logic [31:0]      jal_pc_o,
  output logic [31:0]      alu_out_o,
  output logic [IM_AW-1:0] dm_addr_o,
  output logic [31:0]      slt_out_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             mem_write_o,
  output logic             reg_write_o,
  output logic [1:0]       mem_to_reg_o,
  output logic [1:0]       reg_dst_o,
  output logic [1:0]       ext_op_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [5:0]  op, funct;
  logic [1:0]  aluctr;
  logic        alu_src, branch, jump, jr;
  logic [31:0] alu_b, alu_res;

  assign op    = ins_i[31:26];
  assign funct = ins_i[5:0];

  always_comb begin
    reg_write_o  = 1'b0;
    mem_write_o  = 1'b0;
    mem_to_reg_o = 2'b00;
    reg_dst_o    = 2'b00;
    ext_op_o     = 2'b00;
    aluctr       = 2'b00;
    alu_src      = 1'b0;
    branch       = 1'b0;
    jump         = 1'b0;
    jr           = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h21: begin reg_write_o = 1'b1; reg_dst_o = 2'b01; end
          6'h23: begin reg_write_o = 1'b1; reg_dst_o = 2'b01; aluctr = 2'b01; end
`ifdef SLT_EN
          6'h2A: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = 2'b01;
            mem_to_reg_o = 2'b11;
            aluctr       = 2'b01;
          end
`endif
          6'h08: jr = 1'b1;
          default: ;
        endcase
      end
      6'h0D: begin reg_write_o = 1'b1; alu_src = 1'b1; aluctr = 2'b10; end
      6'h08: begin reg_write_o = 1'b1; alu_src = 1'b1; ext_op_o = 2'b01; aluctr = 2'b11; end
      6'h0F: begin reg_write_o = 1'b1; alu_src = 1'b1; ext_op_o = 2'b10; end
      6'h23: begin
        reg_write_o  = 1'b1;
        alu_src      = 1'b1;
        ext_op_o     = 2'b01;
        mem_to_reg_o = 2'b01;
      end
      6'h2B: begin mem_write_o = 1'b1; alu_src = 1'b1; ext_op_o = 2'b01; end
      6'h04: begin branch = 1'b1; aluctr = 2'b01; end
      6'h02: jump = 1'b1;
      6'h03: begin
        jump         = 1'b1;
        reg_write_o  = 1'b1;
        reg_dst_o    = 2'b10;
        mem_to_reg_o = 2'b10;
      end
      default: ;
    endcase
  end

  assign alu_b = alu_src ? ext_imm_i : rt_data_i;

  always_comb begin
    case (aluctr)
      2'b01:   alu_res = rs_data_i - alu_b;
      2'b10:   alu_res = rs_data_i | alu_b;
      default: alu_res = rs_data_i + alu_b;
    endcase
  end

  assign alu_out_o  = alu_res;
  assign dm_addr_o  = alu_res[IM_AW+1:2];
  assign zero_o     = (alu_res == 32'h0);
  // Signed overflow only matters for addi; plain add/sub wrap silently.
  assign overflow_o = (aluctr == 2'b11) && (rs_data_i[31] == alu_b[31]) &&
                      (alu_res[31] != rs_data_i[31]);

`ifdef SLT_EN
  assign slt_out_o = {31'h0, ($signed(rs_data_i) < $signed(alu_b))};
`else
  assign slt_out_o = 32'h0;
`endif

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    if (jr)
      pc_d = rs_data_i;
    else if (jump)
      pc_d = {pc_q[31:28], ins_i[25:0], 2'b00};
    else if (branch && zero_o)
      pc_d = pc_plus4 + {{14{ins_i[15]}}, ins_i[15:0], 2'b00};
    else
      pc_d = pc_plus4;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pc_q <= RESET_PC;
    else          pc_q <= pc_d;
  end

  assign pc_o      = pc_q;
  assign im_addr_o = pc_q[IM_AW+1:2];
  assign jal_pc_o  = pc_plus4;

endmodule

// File: tb/tb_mips_core_ctrl_exec.sv
// tb/tb_mips_core_ctrl_exec.sv - directed bench for mips_core_ctrl_exec
module tb_mips_core_ctrl_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins, rs_data, rt_data, ext_imm;
  logic [31:0] pc, jal_pc, alu_out, slt_out;
  logic [9:0]  im_addr, dm_addr;
  logic        zero, overflow, mem_write, reg_write;
  logic [1:0]  mem_to_reg, reg_dst, ext_op;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mips_core_ctrl_exec dut (
    .clk_i(clk), .rst_n_i(rst_n), .ins_i(ins), .rs_data_i(rs_data),
    .rt_data_i(rt_data), .ext_imm_i(ext_imm), .pc_o(pc), .im_addr_o(im_addr),
    .jal_pc_o(jal_pc), .alu_out_o(alu_out), .dm_addr_o(dm_addr),
    .slt_out_o(slt_out), .zero_o(zero), .overflow_o(overflow),
    .mem_write_o(mem_write), .reg_write_o(reg_write),
    .mem_to_reg_o(mem_to_reg), .reg_dst_o(reg_dst), .ext_op_o(ext_op)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] ei);
    ins = i; rs_data = rs; rt_data = rt; ext_imm = ei;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(32'h0C00_0C04, 32'h0, 32'h0, 32'h0);
    #12;
    chk("reset_pc", pc, 32'h0000_3000);
    chk("reset_im_addr", {22'h0, im_addr}, 32'h0);
    chk("reset_jal_pc", jal_pc, 32'h0000_3004);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // jal at 3000 with target 000_0C04
    chk("jal_jal_pc", jal_pc, 32'h0000_3004);
    chk("jal_reg_dst", {30'h0, reg_dst}, 32'h2);
    chk("jal_mem_to_reg", {30'h0, mem_to_reg}, 32'h2);
    chk("jal_reg_write", {31'h0, reg_write}, 32'h1);
    step();
    chk("jal_next_pc", pc, 32'h0000_3010);
    // asynchronous reset mid-run, no clock edge in between
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0000_3000);
    chk("async_rst_im_addr", {22'h0, im_addr}, 32'h0);
    rst_n = 1'b1;
    // addu: wraps without overflow
    drive(32'h0000_0021, 32'h7FFF_FFFF, 32'h1, 32'h0);
    chk("addu_alu", alu_out, 32'h8000_0000);
    chk("addu_ovf", {31'h0, overflow}, 32'h0);
    chk("addu_reg_write", {31'h0, reg_write}, 32'h1);
    chk("addu_reg_dst", {30'h0, reg_dst}, 32'h1);
    step();
    chk("addu_next_pc", pc, 32'h0000_3004);
    // addi: signed overflow flagged
    drive(32'h2000_0001, 32'h7FFF_FFFF, 32'h0, 32'h1);
    chk("addi_ovf", {31'h0, overflow}, 32'h1);
    chk("addi_reg_write", {31'h0, reg_write}, 32'h1);
    chk("addi_ext_op", {30'h0, ext_op}, 32'h1);
    step();
    chk("addi_next_pc", pc, 32'h0000_3008);
    // beq taken with offset -1 word loops to itself
    drive(32'h1000_FFFF, 32'h5, 32'h5, 32'h0);
    chk("beq_zero", {31'h0, zero}, 32'h1);
    chk("beq_reg_write", {31'h0, reg_write}, 32'h0);
    step();
    chk("beq_taken_pc", pc, 32'h0000_3008);
    drive(32'h1000_FFFF, 32'h5, 32'h6, 32'h0);
    chk("beq_nz_zero", {31'h0, zero}, 32'h0);
    step();
    chk("beq_not_taken_pc", pc, 32'h0000_300C);
    // jr
    drive(32'h0000_0008, 32'h0000_3004, 32'h0, 32'h0);
    chk("jr_reg_write", {31'h0, reg_write}, 32'h0);
    step();
    chk("jr_next_pc", pc, 32'h0000_3004);
    // sw
    drive(32'hAC00_0004, 32'h10, 32'h0, 32'h4);
    chk("sw_mem_write", {31'h0, mem_write}, 32'h1);
    chk("sw_dm_addr", {22'h0, dm_addr}, 32'h5);
    chk("sw_reg_write", {31'h0, reg_write}, 32'h0);
    // ori
    drive(32'h3400_000F, 32'hF0, 32'h0, 32'hF);
    chk("ori_alu", alu_out, 32'hFF);
    chk("ori_ext_op", {30'h0, ext_op}, 32'h0);
    chk("ori_reg_dst", {30'h0, reg_dst}, 32'h0);
    // lui
    drive(32'h3C00_1234, 32'h0, 32'h0, 32'h1234_0000);
    chk("lui_alu", alu_out, 32'h1234_0000);
    chk("lui_ext_op", {30'h0, ext_op}, 32'h2);
    // lw
    drive(32'h8C00_0008, 32'h100, 32'h0, 32'h8);
    chk("lw_mem_to_reg", {30'h0, mem_to_reg}, 32'h1);
    chk("lw_alu", alu_out, 32'h108);
    chk("lw_mem_write", {31'h0, mem_write}, 32'h0);
    // subu to zero
    drive(32'h0000_0023, 32'h5, 32'h5, 32'h0);
    chk("subu_alu", alu_out, 32'h0);
    chk("subu_zero", {31'h0, zero}, 32'h1);
    // unknown opcode: no strobes, PC advances by 4
    drive(32'hFC00_0000, 32'h0, 32'h0, 32'h0);
    chk("unk_reg_write", {31'h0, reg_write}, 32'h0);
    chk("unk_mem_write", {31'h0, mem_write}, 32'h0);
    chk("unk_selects", {26'h0, mem_to_reg, reg_dst, ext_op}, 32'h0);
    step();
    chk("unk_next_pc", pc, 32'h0000_3008);
    // slt
    drive(32'h0000_002A, 32'hFFFF_FFFF, 32'h1, 32'h0);
`ifdef SLT_EN
    chk("slt_out", slt_out, 32'h1);
    chk("slt_mem_to_reg", {30'h0, mem_to_reg}, 32'h3);
    chk("slt_reg_write", {31'h0, reg_write}, 32'h1);
`else
    chk("slt_out_off", slt_out, 32'h0);
    chk("slt_reg_write_off", {31'h0, reg_write}, 32'h0);
`endif
    // misaligned jr target is not forced
    drive(32'h0000_0008, 32'h0000_3001, 32'h0, 32'h0);
    step();
    chk("jr_misaligned_pc", pc, 32'h0000_3001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
